// File: rtl/log2_arb_pkg.sv
// Shared types and widths for the log2 arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, datapath width, requester-id width.
package log2_arb_pkg;

   localparam int DATA_W = 32;
   localparam int ID_W   = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/log2_32b.sv
// Combinational floor(log2(x)) of a 32-bit operand; x=0 yields all ones.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: i_x operand in, o_y zero-extended index of the highest set bit.
module log2_32b (
   input  logic [31:0] i_x,
   output logic [31:0] o_y
);

   always_comb begin
      o_y = 32'hFFFF_FFFF;
      // Ascending scan: the highest set bit is the last one written.
      for (int b = 0; b < 32; b++) begin
         if (i_x[b]) o_y = 32'(b);
      end
   end

endmodule

// File: rtl/log2_arb.sv
// Round-robin arbiter sharing one log2_32b core among NREQ requesters.
// Latency: CALC_CYCLES+1 cycles from the grant cycle to the first rsp_valid cycle.
// Backpressure: response held stable until rsp_ready; no new grant while busy.
// Ports: clk, rst_n (async active-low), req_valid/req_data/req_ready per requester,
//        rsp_valid/rsp_ready handshake with rsp_data, rsp_id, rsp_err.
// Build option: LOG2_ARB_ZERO_FLAG_EN flags zero operands (rsp_err=1, rsp_data=0).
module log2_arb
   import log2_arb_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int CALC_CYCLES = 1
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [32*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DATA_W-1:0]    rsp_data,
   output logic [ID_W-1:0]      rsp_id,
   output logic                 rsp_err
);

   state_t              r_state;
   logic [ID_W-1:0]     r_rr_ptr;
   logic [ID_W-1:0]     r_id;
   logic [3:0]          r_cnt;
   logic [DATA_W-1:0]   r_op;
   logic [DATA_W-1:0]   r_res;
   logic                r_rsp_vld;

   logic                w_gnt_vld;
   logic [ID_W-1:0]     w_gnt_id;
   logic [NREQ-1:0]     w_gnt_oh;
   logic [DATA_W-1:0]   w_gnt_op;
   logic [DATA_W-1:0]   w_core_y;
   logic [DATA_W-1:0]   w_res_nxt;
   int                  w_dist;
   int                  w_best;

   // Round-robin pick: the valid requester closest to r_rr_ptr (walking
   // upward with wrap) wins; distance avoids a variable-index rotate.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_id  = '0;
      w_gnt_oh  = '0;
      w_gnt_op  = '0;
      w_best    = NREQ;
      w_dist    = 0;
      for (int i = 0; i < NREQ; i++) begin
         w_dist = (i + NREQ - int'(r_rr_ptr)) % NREQ;
         if (req_valid[i] && (w_dist < w_best)) begin
            w_best    = w_dist;
            w_gnt_vld = 1'b1;
            w_gnt_id  = ID_W'(i);
            w_gnt_oh  = '0;
            w_gnt_oh[i] = 1'b1;
            w_gnt_op  = req_data[32*i +: 32];
         end
      end
   end

   // rst_n gates the strobe so nothing is accepted while reset is held.
   assign req_ready = (rst_n && (r_state == IDLE)) ? w_gnt_oh : '0;

   // The core only ever sees the captured operand.
   log2_32b u_core (
      .i_x (r_op),
      .o_y (w_core_y)
   );

`ifdef LOG2_ARB_ZERO_FLAG_EN
   logic r_err;

   assign w_res_nxt = (r_op == '0) ? '0 : w_core_y;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if ((r_state == CALC) && (r_cnt == 4'd0)) begin
         r_err <= (r_op == '0);
      end
   end

   assign rsp_err = r_err;
`else
   assign w_res_nxt = w_core_y;
   assign rsp_err   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_rr_ptr  <= '0;
         r_id      <= '0;
         r_cnt     <= '0;
         r_op      <= '0;
         r_res     <= '0;
         r_rsp_vld <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_gnt_vld) begin
                  r_op    <= w_gnt_op;
                  r_id    <= w_gnt_id;
                  r_cnt   <= 4'(CALC_CYCLES - 1);
                  r_state <= CALC;
               end
            end
            CALC: begin
               if (r_cnt == 4'd0) begin
                  r_res     <= w_res_nxt;
                  r_rsp_vld <= 1'b1;
                  r_state   <= RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_vld <= 1'b0;
                  r_state   <= IDLE;
                  r_rr_ptr  <= (r_id == ID_W'(NREQ - 1)) ? '0 : r_id + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rsp_valid = r_rsp_vld;
   assign rsp_data  = r_res;
   assign rsp_id    = r_id;

endmodule

// File: tb/tb_log2_arb.sv
// Directed bench for log2_arb with a response scoreboard.
// Latency: checks CALC_CYCLES+1 grant-to-response timing on two instances.
// Backpressure: exercises rsp_ready low while a response is held.
module tb_log2_arb;

   typedef struct packed {
      logic [2:0]  id;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic          clk;
   logic          rst_n, rst4_n;
   logic [3:0]    req_valid, req_ready, v4, rdy4;
   logic [127:0]  req_data, d4;
   logic          rsp_valid, rsp_ready, rv4, rr4;
   logic [31:0]   rsp_data, data4;
   logic [2:0]    rsp_id, id4;
   logic          rsp_err, err4;

   int            checks;
   int            failures;
   int            seen;
   exp_t          sb[$];

   log2_arb #(.NREQ(4), .CALC_CYCLES(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err)
   );

   log2_arb #(.NREQ(4), .CALC_CYCLES(4)) u_dut4 (
      .clk(clk), .rst_n(rst4_n), .req_valid(v4), .req_data(d4),
      .req_ready(rdy4), .rsp_valid(rv4), .rsp_ready(rr4),
      .rsp_data(data4), .rsp_id(id4), .rsp_err(err4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference log2: count right shifts until the operand empties.
   function automatic logic [31:0] ref_log2(input logic [31:0] x);
      logic [31:0] t;
      int n;
      t = x;
      n = -1;
      while (t != 32'd0) begin
         t = t >> 1;
         n++;
      end
      return (n < 0) ? 32'hFFFF_FFFF : 32'(n);
   endfunction

   function automatic exp_t mk_exp(input logic [2:0] id, input logic [31:0] op);
      exp_t e;
      e.id = id;
`ifdef LOG2_ARB_ZERO_FLAG_EN
      e.data = (op == 32'd0) ? 32'd0 : ref_log2(op);
      e.err  = (op == 32'd0);
`else
      e.data = ref_log2(op);
      e.err  = 1'b0;
`endif
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int n = 0; n < 50 && sb.size() != 0; n++) step();
      check("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   // Response monitor: pops the scoreboard on every completed handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_rsp id=%0d data=%0h", rsp_id, rsp_data);
            end else begin
               e = sb.pop_front();
               check("rsp_data", rsp_data, e.data);
               check("rsp_id", 32'(rsp_id), 32'(e.id));
               check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] op;
      checks = 0;
      failures = 0;
      rst_n = 1'b0; rst4_n = 1'b0;
      req_valid = 4'b1111; req_data = '0; rsp_ready = 1'b1;
      v4 = 4'b0000; d4 = '0; rr4 = 1'b1;

      // Reset state, including no accept while requests are pending.
      @(negedge clk); @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst4_rsp_valid", 32'(rv4), 32'd0);
      step(); req_valid = 4'b0000;
      step(); rst_n = 1'b1; rst4_n = 1'b1;

      // Single request from requester 0, operand 1024.
      step();
      req_valid = 4'b0001; req_data[31:0] = 32'd1024;
      sb.push_back(mk_exp(3'd0, 32'd1024));
      @(negedge clk); check("single_grant", 32'(req_ready), 32'b0001);
      step(); req_valid = 4'b0000;
      @(negedge clk);
      check("single_calc_valid", 32'(rsp_valid), 32'd0);
      check("single_calc_ready", 32'(req_ready), 32'd0);
      @(negedge clk); check("single_latency", 32'(rsp_valid), 32'd1);
      drain();

      // Zero operand through requester 3 (also returns rr_ptr to 0).
      step();
      req_valid = 4'b1000; req_data[127:96] = 32'd0;
      sb.push_back(mk_exp(3'd3, 32'd0));
      @(negedge clk); check("zero_grant", 32'(req_ready), 32'b1000);
      step(); req_valid = 4'b0000;
      drain();

      // Fairness: all valid, grants 0,1,2,3,0 one every 3 cycles.
      step();
      for (int i = 0; i < 4; i++) req_data[32*i +: 32] = (32'd1 << (4 + i)) | 32'(i);
      req_valid = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         @(negedge clk);
         check("fair_grant", 32'(req_ready), 32'd1 << (g % 4));
         sb.push_back(mk_exp(3'(g % 4), (32'd1 << (4 + (g % 4))) | 32'(g % 4)));
         if (g == 4) begin
            step(); req_valid = 4'b0000;
         end
         @(negedge clk); check("fair_gap1", 32'(req_ready), 32'd0);
         @(negedge clk); check("fair_gap2", 32'(req_ready), 32'd0);
      end
      drain();

      // Backpressure: response from requester 2 held 5 cycles; requester 0 waits.
      step();
      rsp_ready = 1'b0;
      req_valid = 4'b0101;
      req_data[95:64] = 32'h8000_0001;
      req_data[31:0]  = 32'd7;
      sb.push_back(mk_exp(3'd2, 32'h8000_0001));
      @(negedge clk); check("bp_grant", 32'(req_ready), 32'b0100);
      @(negedge clk); check("bp_calc_ready", 32'(req_ready), 32'd0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_hold_valid", 32'(rsp_valid), 32'd1);
         check("bp_hold_data", rsp_data, 32'd31);
         check("bp_hold_id", 32'(rsp_id), 32'd2);
         check("bp_hold_ready", 32'(req_ready), 32'd0);
      end
      step(); rsp_ready = 1'b1;
      sb.push_back(mk_exp(3'd0, 32'd7));
      @(negedge clk); check("bp_release_ready", 32'(req_ready), 32'd0);
      @(negedge clk); check("bp_next_grant", 32'(req_ready), 32'b0001);
      step(); req_valid = 4'b0000;
      drain();

      // Operand replay through requester 3: boundaries then random values.
      for (int n = 0; n < 60; n++) begin
         case (n)
            0: op = 32'd1;
            1: op = 32'd2;
            2: op = 32'd3;
            3: op = 32'hFFFF_FFFF;
            4: op = 32'h8000_0000;
            5: op = 32'd0;
            default: op = $urandom() >> $urandom_range(0, 31);
         endcase
         step();
         req_valid = 4'b1000; req_data[127:96] = op;
         sb.push_back(mk_exp(3'd3, op));
         @(negedge clk); check("replay_grant", 32'(req_ready), 32'b1000);
         step(); req_valid = 4'b0000;
         drain();
      end

      // CALC_CYCLES=4 instance: reset mid-CALC discards the operation.
      step();
      v4 = 4'b0001; d4[31:0] = 32'd100;
      @(negedge clk); check("c4_grant0", 32'(rdy4), 32'b0001);
      step(); v4 = 4'b0000;
      step();
      rst4_n = 1'b0;
      @(negedge clk);
      check("c4_rst_valid", 32'(rv4), 32'd0);
      check("c4_rst_ready", 32'(rdy4), 32'd0);
      check("c4_rr_ptr", 32'(u_dut4.r_rr_ptr), 32'd0);
      step(); rst4_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (rv4) seen++;
      end
      check("c4_no_rsp", 32'(seen), 32'd0);

      // Requester 2 then completes with latency CALC_CYCLES+1 = 5.
      step();
      v4 = 4'b0100; d4[95:64] = 32'h0001_0000;
      @(negedge clk); check("c4_grant2", 32'(rdy4), 32'b0100);
      step(); v4 = 4'b0000;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk); check("c4_calc_valid", 32'(rv4), 32'd0);
      end
      @(negedge clk);
      check("c4_latency", 32'(rv4), 32'd1);
      check("c4_data", data4, 32'd16);
      check("c4_id", 32'(id4), 32'd2);
      check("c4_err", 32'(err4), 32'd0);

      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
